// File: rtl/fifo_math_pkg.sv
// rtl/fifo_math_pkg.sv - shared state type and saturation limits for the fifo math stages
package fifo_math_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FIX, WRITE} div_state_t;

  localparam int MAX_BITS = 64;

  // Limits are built at MAX_BITS and sliced to the stage width by the caller.
  function automatic logic [MAX_BITS-1:0] sat_max(input int bits);
    return (MAX_BITS'(1) << (bits - 1)) - MAX_BITS'(1);
  endfunction

  function automatic logic [MAX_BITS-1:0] sat_min(input int bits);
    return MAX_BITS'(1) << (bits - 1);
  endfunction

endpackage

// File: rtl/divide.sv
// rtl/divide.sv - divider stage plus its result FIFO, presenting a FIFO read port downstream
module divide #(
  parameter int D_BITS = 32,
  parameter int Q_BITS = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [D_BITS-1:0] num,
  input  logic [D_BITS-1:0] den,
  input  logic              in_empty,
  output logic              in_rd_en,
  output logic [D_BITS-1:0] out,
  output logic              div_zero,
  output logic              out_empty,
  input  logic              out_rd_en
);

  logic [D_BITS-1:0] q;
  logic              dz;
  logic              full;
  logic              wr_en;
  logic [D_BITS:0]   dout;

  divide_module #(
    .D_BITS (D_BITS),
    .Q_BITS (Q_BITS)
  ) u_div (
    .clock     (clock),
    .reset     (reset),
    .num       (num),
    .den       (den),
    .in_empty  (in_empty),
    .in_rd_en  (in_rd_en),
    .out       (q),
    .div_zero  (dz),
    .out_full  (full),
    .out_wr_en (wr_en)
  );

  fifo #(
    .WIDTH (D_BITS + 1),
    .DEPTH (D_BITS * 16)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .wr_en (wr_en),
    .din   ({dz, q}),
    .full  (full),
    .rd_en (out_rd_en),
    .dout  (dout),
    .empty (out_empty)
  );

  assign {div_zero, out} = dout;

endmodule

// File: rtl/fifo.sv
// rtl/fifo.sv - show-ahead synchronous FIFO, dout valid whenever !empty
module fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 512
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Extra pointer bit distinguishes full from empty when the addresses match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (wr_en && !full) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (rd_en && !empty) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/udiv_iter.sv
// rtl/udiv_iter.sv - unsigned radix-2 restoring divider core, one quotient bit per cycle
module udiv_iter #(
  parameter int D_BITS = 32,
  parameter int N      = 48
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [N-1:0]      dividend,
  input  logic [D_BITS-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [N-1:0]      quotient
);

  localparam int CW = $clog2(N);

  logic [CW-1:0]     count;
  logic [D_BITS-1:0] rem;
  logic [D_BITS-1:0] dsor;
  logic [N-1:0]      dq;
  logic [D_BITS:0]   trial;
  logic [D_BITS:0]   diff;
  logic              fits;

  // dq starts as the dividend and is shifted out MSB-first while quotient bits enter at the LSB.
  always_comb begin
    trial = {rem, dq[N-1]};
    diff  = trial - {1'b0, dsor};
    fits  = (trial >= {1'b0, dsor});
  end

  assign done     = busy && (count == CW'(N - 1));
  assign quotient = dq;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy  <= 1'b0;
      count <= '0;
      rem   <= '0;
      dsor  <= '0;
      dq    <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      count <= '0;
      rem   <= '0;
      dsor  <= divisor;
      dq    <= dividend;
    end else if (busy) begin
      rem   <= fits ? diff[D_BITS-1:0] : trial[D_BITS-1:0];
      dq    <= {dq[N-2:0], fits};
      count <= done ? '0 : count + CW'(1);
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/divide_module.sv
// rtl/divide_module.sv - signed fixed-point divider stage: out = (num << Q_BITS) / den
module divide_module
  import fifo_math_pkg::*;
#(
  parameter int D_BITS = 32,
  parameter int Q_BITS = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [D_BITS-1:0] num,
  input  logic [D_BITS-1:0] den,
  input  logic              in_empty,
  output logic              in_rd_en,
  output logic [D_BITS-1:0] out,
  output logic              div_zero,
  input  logic              out_full,
  output logic              out_wr_en
);

  localparam int N = D_BITS + Q_BITS;
  localparam logic [MAX_BITS-1:0] MAX_W   = sat_max(D_BITS);
  localparam logic [MAX_BITS-1:0] MIN_W   = sat_min(D_BITS);
  localparam logic [D_BITS-1:0]   SAT_MAX = MAX_W[D_BITS-1:0];
  localparam logic [D_BITS-1:0]   SAT_MIN = MIN_W[D_BITS-1:0];
  localparam logic [N-1:0]        POS_LIM = N'(SAT_MAX);
  localparam logic [N-1:0]        NEG_LIM = N'(SAT_MIN);

  div_state_t        state;
  div_state_t        state_next;
  logic              accept;
  logic              neg;
  logic              num_neg;
  logic              den_zero;
  logic [D_BITS-1:0] num_mag;
  logic [D_BITS-1:0] den_mag;
  logic [N-1:0]      dividend;
  logic [N-1:0]      quotient;
  logic              core_busy;
  logic              core_done;
  logic [D_BITS-1:0] fix_out;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)     state_next = CALC;
      CALC:    if (core_done)  state_next = FIX;
      FIX:                     state_next = WRITE;
      WRITE:   if (!out_full)  state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Handshake pulses are combinational so the pop lands in the accept cycle itself.
  always_comb begin
    in_rd_en  = (state == IDLE) && !in_empty && !core_busy && !reset;
    out_wr_en = (state == WRITE) && !out_full;
  end

  assign accept = in_rd_en;

  // Unsigned magnitudes keep |-2^(D_BITS-1)| exact.
  always_comb begin
    num_mag  = num[D_BITS-1] ? -num : num;
    den_mag  = den[D_BITS-1] ? -den : den;
    dividend = {num_mag, {Q_BITS{1'b0}}};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      neg      <= 1'b0;
      num_neg  <= 1'b0;
      den_zero <= 1'b0;
    end else if (accept) begin
      neg      <= num[D_BITS-1] ^ den[D_BITS-1];
      num_neg  <= num[D_BITS-1];
      den_zero <= (den == '0);
    end
  end

  udiv_iter #(
    .D_BITS (D_BITS),
    .N      (N)
  ) u_core (
    .clock    (clock),
    .reset    (reset),
    .start    (accept),
    .dividend (dividend),
    .divisor  (den_mag),
    .busy     (core_busy),
    .done     (core_done),
    .quotient (quotient)
  );

  always_comb begin
    fix_out = quotient[D_BITS-1:0];
    if (den_zero) begin
      fix_out = num_neg ? SAT_MIN : SAT_MAX;
    end else if (neg) begin
      fix_out = (quotient > NEG_LIM) ? SAT_MIN : -quotient[D_BITS-1:0];
    end else if (quotient > POS_LIM) begin
      fix_out = SAT_MAX;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out      <= '0;
      div_zero <= 1'b0;
    end else if (state == FIX) begin
      out      <= fix_out;
      div_zero <= den_zero;
    end
  end

endmodule

// File: tb/tb_divide_module.sv
// tb/tb_divide_module.sv - randomized and directed bench for divide_module against an arithmetic model
module tb_divide_module;

  localparam int D_BITS = 32;
  localparam int Q_BITS = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] num;
  logic [31:0] den;
  logic        in_empty;
  logic        in_rd_en;
  logic [31:0] out;
  logic        div_zero;
  logic        out_full;
  logic        out_wr_en;

  divide_module #(
    .D_BITS (D_BITS),
    .Q_BITS (Q_BITS)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .num       (num),
    .den       (den),
    .in_empty  (in_empty),
    .in_rd_en  (in_rd_en),
    .out       (out),
    .div_zero  (div_zero),
    .out_full  (out_full),
    .out_wr_en (out_wr_en)
  );

  always #5 clock = ~clock;

  typedef struct { logic [31:0] num; logic [31:0] den; } op_t;
  typedef struct { logic [31:0] out; logic dz; } res_t;
  typedef struct { logic [31:0] n; logic [31:0] d; logic [31:0] o; logic z; } vec_t;

  op_t  op_q[$];
  res_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   rd_count = 0;
  int   wr_count = 0;
  int   last_rd_cyc = 0;
  int   last_wr_cyc = 0;
  logic [31:0] last_out = '0;
  logic        last_dz = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Signed quotient scaled by 2^Q_BITS, truncated toward zero, then clamped to 32 bits.
  function automatic res_t ref_div(input logic [31:0] n, input logic [31:0] d);
    res_t   r;
    longint q;
    if (d == 32'h0) begin
      r.dz  = 1'b1;
      r.out = ($signed(n) < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      return r;
    end
    r.dz = 1'b0;
    q = (longint'($signed(n)) * 65536) / longint'($signed(d));
    if (q > 64'sd2147483647)        r.out = 32'h7FFF_FFFF;
    else if (q < -64'sd2147483648)  r.out = 32'h8000_0000;
    else                            r.out = q[31:0];
    return r;
  endfunction

  // Upstream FIFO model plus downstream scoreboard; samples on the falling edge.
  initial begin
    logic rd_seen;
    logic wr_seen;
    op_t  o;
    res_t e;
    in_empty = 1'b1;
    num = '0;
    den = '0;
    forever begin
      @(negedge clock);
      cyc++;
      rd_seen = in_rd_en;
      wr_seen = out_wr_en;
      if (rd_seen && wr_seen) check("rd_wr_overlap", 1, 0);
      if (rd_seen) begin
        rd_count++;
        last_rd_cyc = cyc;
        if (op_q.size() == 0) check("rd_when_empty", 1, 0);
        else begin
          o = op_q.pop_front();
          exp_q.push_back(ref_div(o.num, o.den));
        end
      end
      if (wr_seen) begin
        wr_count++;
        last_wr_cyc = cyc;
        last_out = out;
        last_dz = div_zero;
        if (exp_q.size() == 0) check("wr_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("sb_out", out, e.out);
          check("sb_dz", div_zero, e.dz);
        end
      end
      @(posedge clock);
      #1;
      if (op_q.size() > 0) begin
        in_empty = 1'b0;
        num = op_q[0].num;
        den = op_q[0].den;
      end else begin
        in_empty = 1'b1;
        num = $urandom;
        den = $urandom;
      end
    end
  end

  task automatic wait_wr(input int target, input int budget);
    int n = 0;
    while (wr_count < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("wr_timeout", wr_count >= target, 1);
  endtask

  task automatic wait_rd(input int target, input int budget);
    int n = 0;
    while (rd_count < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("rd_timeout", rd_count >= target, 1);
  endtask

  initial begin
    vec_t v[8];
    op_t  o;
    int   base_rd;
    int   base_wr;
    logic [31:0] hold;

    v[0] = '{32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 1'b0};
    v[1] = '{32'hFFFF_0000, 32'h0003_0000, 32'hFFFF_AAAB, 1'b0};
    v[2] = '{32'h0001_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1};
    v[3] = '{32'hFFFF_0000, 32'h0000_0000, 32'h8000_0000, 1'b1};
    v[4] = '{32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1};
    v[5] = '{32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0};
    v[6] = '{32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 1'b0};
    v[7] = '{32'h8000_0000, 32'hFFFF_0000, 32'h7FFF_FFFF, 1'b0};

    reset = 1'b1;
    out_full = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_out", out, 0);
    check("rst_dz", div_zero, 0);
    check("rst_rd", in_rd_en, 0);
    check("rst_wr", out_wr_en, 0);
    @(posedge clock);
    #2;
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      base_wr = wr_count;
      op_q.push_back('{v[i].n, v[i].d});
      wait_wr(base_wr + 1, 100);
      check($sformatf("vec%0d_out", i), last_out, v[i].o);
      check($sformatf("vec%0d_dz", i), last_dz, v[i].z);
      if (i == 0) begin
        check("first_rd_count", rd_count, 1);
        check("latency", last_wr_cyc - last_rd_cyc, 50);
      end
    end

    // Back-pressure held for 10 cycles while the result sits in WRITE.
    out_full = 1'b1;
    base_rd = rd_count;
    base_wr = wr_count;
    op_q.push_back('{32'h0007_0000, 32'h0002_0000});
    op_q.push_back('{32'hFFFE_0000, 32'h0004_0000});
    wait_rd(base_rd + 1, 20);
    repeat (53) @(negedge clock);
    hold = out;
    repeat (10) @(negedge clock);
    check("full_out_stable", out, hold);
    check("full_out_val", out, 32'h0003_8000);
    check("full_no_wr", wr_count, base_wr);
    check("full_no_rd", rd_count, base_rd + 1);
    @(posedge clock);
    #1;
    out_full = 1'b0;
    wait_wr(base_wr + 1, 10);
    wait_rd(base_rd + 2, 10);
    check("full_one_wr", wr_count, base_wr + 1);
    wait_wr(base_wr + 2, 100);
    check("full_next_out", last_out, 32'hFFFF_8000);

    // Reset in the middle of CALC abandons the operation.
    base_rd = rd_count;
    base_wr = wr_count;
    op_q.push_back('{32'h0007_0000, 32'h0003_0000});
    op_q.push_back('{32'h0005_0000, 32'h0001_0000});
    wait_rd(base_rd + 1, 20);
    repeat (19) @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_out", out, 0);
    check("mid_rst_dz", div_zero, 0);
    exp_q.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("mid_rst_rd_blocked", rd_count, base_rd + 1);
    wait_wr(base_wr + 1, 120);
    check("post_rst_out", last_out, 32'h0005_0000);
    check("post_rst_dz", last_dz, 0);
    check("post_rst_rd", rd_count, base_rd + 2);
    check("no_abandoned_wr", wr_count, base_wr + 1);

    // Streaming random operands.
    base_rd = rd_count;
    base_wr = wr_count;
    for (int i = 0; i < 8; i++) begin
      o.num = $urandom;
      case ($urandom_range(0, 2))
        0:       o.den = $urandom;
        1:       o.den = $urandom >> $urandom_range(8, 28);
        default: o.den = 32'($signed(16'($urandom)));
      endcase
      if (i == 5) o.den = 32'h0;
      op_q.push_back(o);
    end
    wait_wr(base_wr + 8, 8 * 60);
    check("stream_rd_count", rd_count - base_rd, 8);
    check("stream_wr_count", wr_count - base_wr, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
